// File: rtl/clockgen_pkg.sv
// Shared definitions for the multi-phase clock-enable generator:
// FSM state encoding and a constant-width helper.
package clockgen_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACTIVE = ST_ACTIVE,
        DEAD   = ST_DEAD,
        HOLD   = ST_HOLD
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) < value) begin
                result = r + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/multiphase_clockgen.sv
// Non-overlapping NPHASE clock-enable generator with programmable phase width,
// optional dead time, slot-boundary wait-state hold and run enable.
//
// state  | meaning
// IDLE   | stopped, phi = 0, div_q tracks div
// ACTIVE | phi[phi_idx] high for div_q+1 clocks
// DEAD   | GAP dead clocks after the active window, phi = 0
// HOLD   | wait state, phi = 0, phi_idx already names the next phase
module multiphase_clockgen
    import clockgen_pkg::*;
#(
    parameter int NPHASE = 4,
    parameter int DIVW   = 4,
    parameter int GAP    = 0,
    localparam int IW    = (clog2(NPHASE) > 0) ? clog2(NPHASE) : 1
) (
    input  logic              clk12,
    input  logic              reset,
    input  logic              en,
    input  logic              hold,
    input  logic [DIVW-1:0]   div,
    output logic [NPHASE-1:0] phi,
    output logic [IW-1:0]     phi_idx,
    output logic              cycle_start,
    output logic              phase_start,
    output logic              holding
);

    localparam int GW = clog2(GAP + 1);
    localparam int CW = (DIVW > GW) ? DIVW : GW;
    localparam logic [IW-1:0] LAST_IDX = IW'(NPHASE - 1);
    localparam logic [CW-1:0] GAP_TC   = CW'((GAP > 0) ? GAP - 1 : 0);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [NPHASE-1:0] phi_q, phi_d;
    logic              cycle_start_q, cycle_start_d;
    logic              phase_start_q, phase_start_d;
    logic              holding_q, holding_d;

    logic [IW-1:0]     idx_next;
    logic              boundary;
    logic              launch;
    logic [IW-1:0]     launch_idx;

    function automatic logic [NPHASE-1:0] onehot(input logic [IW-1:0] i);
        return NPHASE'(1) << i;
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        div_d         = div_q;
        phi_d         = '0;
        cycle_start_d = 1'b0;
        phase_start_d = 1'b0;
        holding_d     = 1'b0;
        boundary      = 1'b0;
        launch        = 1'b0;
        launch_idx    = idx_q;
        idx_next      = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

        case (state_q)
            IDLE: begin
                div_d = div;
                if (en) begin
                    launch     = 1'b1;
                    launch_idx = '0;
                end
            end
            ACTIVE: begin
                if (cnt_q == CW'(div_q)) begin
                    if (GAP == 0) begin
                        boundary = 1'b1;
                    end else begin
                        state_d = DEAD;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    phi_d = onehot(idx_q);
                end
            end
            DEAD: begin
                if (cnt_q == GAP_TC) begin
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (hold) begin
                    holding_d = 1'b1;
                end else begin
                    launch = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // hold only matters on the last clock of a slot
        if (boundary) begin
            idx_d = idx_next;
            cnt_d = '0;
            if (hold) begin
                state_d   = HOLD;
                holding_d = 1'b1;
            end else begin
                launch     = 1'b1;
                launch_idx = idx_next;
            end
        end

        if (launch) begin
            state_d       = ACTIVE;
            idx_d         = launch_idx;
            cnt_d         = '0;
            phi_d         = onehot(launch_idx);
            phase_start_d = 1'b1;
            if (launch_idx == '0) begin
                cycle_start_d = 1'b1;
                div_d         = div;
            end
        end

        if (!en) begin
            state_d       = IDLE;
            cnt_d         = '0;
            idx_d         = '0;
            phi_d         = '0;
            cycle_start_d = 1'b0;
            phase_start_d = 1'b0;
            holding_d     = 1'b0;
        end
    end

    always_ff @(posedge clk12) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            div_q         <= div;
            phi_q         <= '0;
            cycle_start_q <= 1'b0;
            phase_start_q <= 1'b0;
            holding_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            div_q         <= div_d;
            phi_q         <= phi_d;
            cycle_start_q <= cycle_start_d;
            phase_start_q <= phase_start_d;
            holding_q     <= holding_d;
        end
    end

    assign phi         = phi_q;
    assign phi_idx     = idx_q;
    assign cycle_start = cycle_start_q;
    assign phase_start = phase_start_q;
    assign holding     = holding_q;

endmodule

// File: tb/tb_multiphase_clockgen.sv
// Bench for multiphase_clockgen: GAP=0 and GAP=1 instances against a slot-position
// reference model, plus a directed vector table and hand-written corner sequences.
module tb_multiphase_clockgen;

    localparam int NP = 4;
    localparam int DW = 4;
    localparam int IW = 2;

    logic          clk12 = 1'b0;
    logic          reset = 1'b1;
    logic          en    = 1'b0;
    logic          hold  = 1'b0;
    logic [DW-1:0] div   = '0;

    logic [NP-1:0] phi0, phi1;
    logic [IW-1:0] idx0, idx1;
    logic          cs0, cs1, ps0, ps1, h0, h1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk12 = ~clk12;

    multiphase_clockgen #(.NPHASE(NP), .DIVW(DW), .GAP(0)) dut0 (
        .clk12(clk12), .reset(reset), .en(en), .hold(hold), .div(div),
        .phi(phi0), .phi_idx(idx0), .cycle_start(cs0), .phase_start(ps0), .holding(h0)
    );

    multiphase_clockgen #(.NPHASE(NP), .DIVW(DW), .GAP(1)) dut1 (
        .clk12(clk12), .reset(reset), .en(en), .hold(hold), .div(div),
        .phi(phi1), .phi_idx(idx1), .cycle_start(cs1), .phase_start(ps1), .holding(h1)
    );

    // Reference: position within the current slot, slot = div+1 active then GAP dead.
    bit         m_run [2];
    bit         m_held[2];
    int         m_idx [2];
    int         m_pos [2];
    int         m_dm  [2];
    logic [8:0] m_exp [2];

    function automatic logic [8:0] pack(int p, int i, bit c, bit s, bit h);
        return {4'(p), 2'(i), c, s, h};
    endfunction

    task automatic model_step(input int m);
        int gap;
        int p;
        bit c, s, h;
        gap = m;
        p = 0; c = 0; s = 0; h = 0;
        if (reset || !en) begin
            m_run[m] = 0; m_held[m] = 0; m_idx[m] = 0; m_pos[m] = 0;
            m_dm[m] = int'(div);
        end else if (!m_run[m]) begin
            m_run[m] = 1; m_idx[m] = 0; m_pos[m] = 0; m_dm[m] = int'(div);
            p = 1; c = 1; s = 1;
        end else if (m_held[m]) begin
            if (hold) begin
                h = 1;
            end else begin
                m_held[m] = 0; m_pos[m] = 0;
                if (m_idx[m] == 0) begin m_dm[m] = int'(div); c = 1; end
                p = 1 << m_idx[m]; s = 1;
            end
        end else if (m_pos[m] == m_dm[m] + gap) begin
            m_idx[m] = (m_idx[m] + 1) % NP;
            m_pos[m] = 0;
            if (hold) begin
                m_held[m] = 1; h = 1;
            end else begin
                if (m_idx[m] == 0) begin m_dm[m] = int'(div); c = 1; end
                p = 1 << m_idx[m]; s = 1;
            end
        end else begin
            m_pos[m] = m_pos[m] + 1;
            if (m_pos[m] <= m_dm[m]) p = 1 << m_idx[m];
        end
        m_exp[m] = pack(p, m_idx[m], c, s, h);
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %b, expected %b ({phi,idx,cs,ps,holding})",
                      name, $time, act, exp);
    endtask

    task automatic tick();
        @(posedge clk12);
        model_step(0);
        model_step(1);
        #1;
        check("model_gap0", {phi0, idx0, cs0, ps0, h0}, m_exp[0]);
        check("model_gap1", {phi1, idx1, cs1, ps1, h1}, m_exp[1]);
        n_total++;
        if ($countones(phi0) <= 1 && $countones(phi1) <= 1) n_pass++;
        else $display("FAIL phi_overlap at %0t: phi0=%b phi1=%b, required at most one bit",
                      $time, phi0, phi1);
    endtask

    typedef struct {
        bit         rst, en, hold;
        logic [3:0] phi;
        logic [1:0] idx;
        bit         cs, ps, h;
    } vec_t;

    function automatic vec_t mk(bit r, bit e, bit ho, int p, int i, bit c, bit s, bit h);
        vec_t v;
        v.rst = r; v.en = e; v.hold = ho;
        v.phi = 4'(p); v.idx = 2'(i); v.cs = c; v.ps = s; v.h = h;
        return v;
    endfunction

    vec_t tbl[20];
    int   exp_a[13] = '{1, 2, 4, 8, 1, 1, 1, 1, 2, 2, 2, 2, 4};

    initial begin
        // GAP=0, div=0: rotation, 3-clock hold over phase-1 boundary, en drop, reset in HOLD
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 1, 0, 1, 1, 0);
        tbl[2]  = mk(0, 1, 0, 2, 1, 0, 1, 0);
        tbl[3]  = mk(0, 1, 1, 0, 2, 0, 0, 1);
        tbl[4]  = mk(0, 1, 1, 0, 2, 0, 0, 1);
        tbl[5]  = mk(0, 1, 1, 0, 2, 0, 0, 1);
        tbl[6]  = mk(0, 1, 0, 4, 2, 0, 1, 0);
        tbl[7]  = mk(0, 1, 0, 8, 3, 0, 1, 0);
        tbl[8]  = mk(0, 1, 0, 1, 0, 1, 1, 0);
        tbl[9]  = mk(0, 1, 0, 2, 1, 0, 1, 0);
        tbl[10] = mk(0, 1, 0, 4, 2, 0, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 1, 0, 1, 0, 1, 1, 0);
        tbl[17] = mk(0, 1, 1, 0, 1, 0, 0, 1);
        tbl[18] = mk(1, 1, 1, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 0, 1, 0, 1, 1, 0);

        div = 4'd0;
        for (int i = 0; i < 20; i++) begin
            reset = tbl[i].rst;
            en    = tbl[i].en;
            hold  = tbl[i].hold;
            tick();
            check($sformatf("vec%0d", i), {phi0, idx0, cs0, ps0, h0},
                  {tbl[i].phi, tbl[i].idx, tbl[i].cs, tbl[i].ps, tbl[i].h});
        end

        // div 0 -> 3 while phase 2 is active: widens from the next phase 0 only
        reset = 1'b1; hold = 1'b0; en = 1'b1; div = 4'd0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 13; k++) begin
            tick();
            check($sformatf("divchg_phi%0d", k), {5'd0, phi0}, {5'd0, 4'(exp_a[k])});
            check($sformatf("divchg_cs%0d", k), {8'd0, cs0}, {8'd0, (k == 0 || k == 4)});
            if (k == 2) div = 4'd3;
        end

        // GAP=1, div=2: three active clocks then one dead clock per phase, period 16
        reset = 1'b1; hold = 1'b0; en = 1'b1; div = 4'd2;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            int slot, off;
            slot = (k / 4) % 4;
            off  = k % 4;
            tick();
            check($sformatf("gap1_k%0d", k), {3'd0, phi1, ps1, cs1},
                  {3'd0, (off < 3) ? 4'(1 << slot) : 4'd0, (off == 0), (off == 0 && slot == 0)});
        end

        // randomized traffic, both instances against the model
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom % 200) == 0;
            en    = ($urandom % 40) != 0;
            hold  = ($urandom % 4) == 0;
            if (($urandom % 16) == 0) div = 4'($urandom_range(0, 3));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
